if_pc_ctrl: RTL and testbench

Instruction-fetch PC controller. It sits directly upstream of the flow-control block and the Icache. It owns the fetch PC and issues fetch requests to the Icache. It applies redirects from flow control (branch/jal/jalr) and produces the request and jump-stop signals that flow control consumes. It also tags each returned instruction with its PC and a valid bit for the if/id pipeline register.

---
 rtl/if_pc_ctrl.sv | 116 +++++++++++
 tb/tb_if_pc_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_ctrl.sv
// Instruction-fetch PC controller: owns the fetch PC, issues Icache requests,
// applies flow-control redirects and tags returned instructions for if/id.
module if_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fc_jump_flag_i,
  input  logic [31:0] fc_jump_pc_i,
  input  logic        fc_Icache_stall_flag_i,
  input  logic        fc_Icache_data_valid_i,
  output logic [31:0] if_pc_o,
  output logic        if_valid_req_o,
  output logic        if_jump_stop_Icache_o,
  output logic [31:0] if_id_pc_o,
  output logic        if_id_valid_o
);

  typedef enum logic [1:0] {
    StResetWait,
    StRun,
    StMissWait,
    StJumpPend
  } state_e;

  localparam logic [31:0] Step = 32'(PC_STEP);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StResetWait;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0;
      id_pc_q    <= 32'h0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Next-state: redirect beats capture beats miss in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    id_pc_d    = id_pc_q;
    id_valid_d = 1'b0;
    unique case (state_q)
      StResetWait: begin
        state_d = StRun;
      end
      StRun: begin
        if (fc_jump_flag_i) begin
          pc_d = fc_jump_pc_i;
        end else if (fc_Icache_data_valid_i) begin
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + Step;
        end else if (fc_Icache_stall_flag_i) begin
          state_d = StMissWait;
        end
      end
      StMissWait: begin
        if (fc_jump_flag_i) begin
          if (fc_Icache_data_valid_i) begin
            // Miss already completed this cycle: redirect directly.
            pc_d    = fc_jump_pc_i;
            state_d = StRun;
          end else begin
            pend_pc_d = fc_jump_pc_i;
            state_d   = StJumpPend;
          end
        end else if (fc_Icache_data_valid_i) begin
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + Step;
          state_d    = StRun;
        end
      end
      StJumpPend: begin
        if (fc_jump_flag_i) begin
          pend_pc_d = fc_jump_pc_i;
        end
        // Refill done (data returned or flow control released): discard it.
        if (fc_Icache_data_valid_i || !fc_Icache_stall_flag_i) begin
          pc_d    = fc_jump_flag_i ? fc_jump_pc_i : pend_pc_q;
          state_d = StRun;
        end
      end
      default: begin
        state_d = StResetWait;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    if_pc_o               = pc_q;
    if_valid_req_o        = (state_q == StRun) || (state_q == StMissWait);
    if_jump_stop_Icache_o = (state_q == StJumpPend);
    if_id_pc_o            = id_pc_q;
    if_id_valid_o         = id_valid_q;
  end

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Self-checking bench for if_pc_ctrl: directed scenarios plus randomized
// stimulus compared against a transaction-level reference model.
module tb_if_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump = 1'b0;
  logic [31:0] jump_pc = 32'h0;
  logic        stall = 1'b0;
  logic        dv = 1'b0;
  logic [31:0] pc;
  logic        req;
  logic        stop;
  logic [31:0] id_pc;
  logic        id_valid;

  // Second instance for the wrap-around case.
  logic        rst2 = 1'b1;
  logic [31:0] pc2;
  logic        req2;
  logic        stop2;
  logic [31:0] id_pc2;
  logic        id_valid2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_pc_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .fc_jump_flag_i         (jump),
    .fc_jump_pc_i           (jump_pc),
    .fc_Icache_stall_flag_i (stall),
    .fc_Icache_data_valid_i (dv),
    .if_pc_o                (pc),
    .if_valid_req_o         (req),
    .if_jump_stop_Icache_o  (stop),
    .if_id_pc_o             (id_pc),
    .if_id_valid_o          (id_valid)
  );

  if_pc_ctrl #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
    .clk                    (clk),
    .rst                    (rst2),
    .fc_jump_flag_i         (1'b0),
    .fc_jump_pc_i           (32'h0),
    .fc_Icache_stall_flag_i (1'b0),
    .fc_Icache_data_valid_i (1'b1),
    .if_pc_o                (pc2),
    .if_valid_req_o         (req2),
    .if_jump_stop_Icache_o  (stop2),
    .if_id_pc_o             (id_pc2),
    .if_id_valid_o          (id_valid2)
  );

  // Reference model: fetch is "warming up", "fetching", "waiting on a miss",
  // or "holding redirects" (queue of targets, newest wins).
  logic [31:0] m_pc;
  logic        m_warm;
  logic        m_miss;
  logic [31:0] m_redirects[$];
  logic        m_idv;
  logic [31:0] m_idpc;

  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0; m_warm = 1'b1; m_miss = 1'b0; m_redirects.delete();
      m_idv = 1'b0; m_idpc = 32'h0;
    end else if (m_warm) begin
      m_warm = 1'b0; m_idv = 1'b0;
    end else if (m_redirects.size() != 0) begin
      m_idv = 1'b0;
      if (jump) m_redirects.push_back(jump_pc);
      if (dv || !stall) begin
        m_pc = m_redirects[$];
        m_redirects.delete();
        m_miss = 1'b0;
      end
    end else if (jump) begin
      m_idv = 1'b0;
      if (m_miss && !dv) m_redirects.push_back(jump_pc);
      else begin m_pc = jump_pc; m_miss = 1'b0; end
    end else if (dv) begin
      m_idv = 1'b1; m_idpc = m_pc; m_pc = m_pc + 32'd4; m_miss = 1'b0;
    end else begin
      m_idv = 1'b0;
      if (stall) m_miss = 1'b1;
    end
  endtask

  // Advance one clock; outputs are then stable for sampling.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic j, input logic [31:0] jpc, input logic s, input logic d);
    jump = j; jump_pc = jpc; stall = s; dv = d;
  endtask

  task automatic test_reset();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    n_checks++;
    if (pc !== 32'h0 || req !== 1'b0 || stop !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h req=%b stop=%b idv=%b idpc=%h, want 0/0/0/0/0",
               pc, req, stop, id_valid, id_pc);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (req !== 1'b1 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wait_len: req=%b pc=%h, want 1/0", req, pc);
    end
  endtask

  task automatic test_sequential();
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (pc !== 32'(4 * k) || req !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_issue[%0d]: pc=%h req=%b, want %h/1", k, pc, req, 32'(4 * k));
      end
      tick();
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL seq_capture[%0d]: idv=%b idpc=%h, want 1/%h", k, id_valid, id_pc,
                 32'(4 * k));
      end
    end
  endtask

  task automatic test_jump();
    set_in(1'b1, 32'h100, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (id_valid !== 1'b0 || pc !== 32'h100 || req !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_kill: idv=%b pc=%h req=%b, want 0/100/1", id_valid, pc, req);
    end
  endtask

  task automatic test_miss();
    set_in(1'b1, 32'h20, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (pc !== 32'h20 || id_valid !== 1'b0 || req !== 1'b1) begin
        n_fail++;
        $display("FAIL miss_hold[%0d]: pc=%h idv=%b req=%b, want 20/0/1", k, pc, id_valid, req);
      end
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h20 || pc !== 32'h24) begin
      n_fail++;
      $display("FAIL miss_done: idv=%b idpc=%h pc=%h, want 1/20/24", id_valid, id_pc, pc);
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic enter_pend(input logic [31:0] target);
    set_in(1'b1, 32'h40, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    set_in(1'b1, target, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_jump_pend();
    enter_pend(32'h200);
    n_checks++;
    if (stop !== 1'b1 || req !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_enter: stop=%b req=%b idv=%b, want 1/0/0", stop, req, id_valid);
    end
    set_in(1'b1, 32'h300, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (stop !== 1'b1 || req !== 1'b0) begin
        n_fail++;
        $display("FAIL pend_hold[%0d]: stop=%b req=%b, want 1/0", k, stop, req);
      end
    end
    set_in(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (stop !== 1'b0 || req !== 1'b1 || pc !== 32'h300 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_done: stop=%b req=%b pc=%h idv=%b, want 0/1/300/0",
               stop, req, pc, id_valid);
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_in_pend();
    enter_pend(32'h500);
    set_in(1'b0, 32'h0, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    n_checks++;
    if (req !== 1'b0 || stop !== 1'b0 || pc !== 32'h0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_pend: req=%b stop=%b pc=%h idv=%b, want 0/0/0/0",
               req, stop, pc, id_valid);
    end
    rst = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc[3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (pc2 !== exp_pc[k] || req2 !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_pc[%0d]: pc=%h req=%b, want %h/1", k, pc2, req2, exp_pc[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (id_valid2 !== 1'b1 || id_pc2 !== exp_pc[k-1]) begin
          n_fail++;
          $display("FAIL wrap_id[%0d]: idv=%b idpc=%h, want 1/%h", k, id_valid2, id_pc2,
                   exp_pc[k-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int errs = 0;
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(0, 99) == 0);
      jump    = ($urandom_range(0, 9) == 0);
      jump_pc = $urandom & 32'hFFFF_FFFC;
      stall   = ($urandom_range(0, 2) != 0);
      dv      = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if (pc !== m_pc || req !== (!m_warm && m_redirects.size() == 0) ||
          stop !== (m_redirects.size() != 0) || id_valid !== m_idv ||
          (m_idv && id_pc !== m_idpc)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: pc=%h req=%b stop=%b idv=%b idpc=%h, want %h/%b/%b/%b/%h",
                   k, pc, req, stop, id_valid, id_pc, m_pc,
                   !m_warm && m_redirects.size() == 0, m_redirects.size() != 0, m_idv, m_idpc);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_miss();
    test_jump_pend();
    test_reset_in_pend();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
